// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// Start/busy/done handshake; the write-back word, index and enable feed the register file.
// Optional feature macro: MULDIV_EARLY_OUT_EN (MUL/MULHU leave RUN once the remaining multiplier bits are zero).
module muldiv_unit #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] SrcA,
  input  logic [N-1:0] SrcB,
  input  logic [M-1:0] RdIn,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Result,
  output logic [M-1:0] RdOut,
  output logic         WE
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt;
  logic [1:0]     op_q;
  logic [N-1:0]   a_q;      // multiplicand
  logic [N-1:0]   b_q;      // divisor
  logic [N-1:0]   mplr;     // remaining multiplier bits, consumed LSB first
  logic [2*N-1:0] acc;      // product accumulator
  logic [N:0]     rem;      // partial remainder
  logic [N-1:0]   quo;      // dividend shifting out, quotient shifting in
  logic           dz;       // divide by zero: resolve after a single RUN cycle

  logic           accept_c;
  logic           last_c;
  logic [N-1:0]   addend_c;
  logic [N:0]     mul_sum_c;
  logic [2*N-1:0] acc_nx_c;
  logic [2*N-1:0] prod_c;
  logic [N:0]     div_sh_c;
  logic [N:0]     div_sub_c;
  logic           div_ge_c;
  logic [N:0]     rem_nx_c;
  logic [N-1:0]   quo_nx_c;
  logic [N-1:0]   res_c;
`ifdef MULDIV_EARLY_OUT_EN
  logic [CW-1:0]  sh_c;
`endif

  // One shift-add multiply step and one restoring divide step, plus result selection.
  always_comb begin
    addend_c  = mplr[0] ? a_q : N'(0);
    mul_sum_c = {1'b0, acc[2*N-1:N]} + {1'b0, addend_c};
    acc_nx_c  = {mul_sum_c, acc[N-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
    // after cnt+1 iterations the product still needs N-1-cnt more right shifts
    sh_c      = CW'(N - 1) - cnt;
    prod_c    = acc_nx_c >> sh_c;
`else
    prod_c    = acc_nx_c;
`endif
    div_sh_c  = {rem[N-1:0], quo[N-1]};
    div_ge_c  = (div_sh_c >= {1'b0, b_q});
    div_sub_c = div_sh_c - {1'b0, b_q};
    rem_nx_c  = div_ge_c ? div_sub_c : div_sh_c;
    quo_nx_c  = {quo[N-2:0], div_ge_c};
    if (dz) begin
      res_c = op_q[0] ? quo : {N{1'b1}};
    end else begin
      unique case (op_q)
        2'b00:   res_c = prod_c[N-1:0];
        2'b01:   res_c = prod_c[2*N-1:N];
        2'b10:   res_c = quo_nx_c;
        default: res_c = rem_nx_c[N-1:0];
      endcase
    end
  end

  // Next-state logic and operand acceptance.
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        last_c = dz || (cnt == CW'(N - 1));
`ifdef MULDIV_EARLY_OUT_EN
        if (!op_q[1] && ((mplr >> 1) == N'(0))) last_c = 1'b1;
`endif
        if (last_c) state_d = DONE;
      end
      default: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Datapath registers, latched operands and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mplr   <= '0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      dz     <= 1'b0;
      Result <= '0;
      RdOut  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      WE     <= 1'b0;
    end else begin
      if (accept_c) begin
        cnt   <= '0;
        op_q  <= op;
        a_q   <= SrcA;
        b_q   <= SrcB;
        mplr  <= SrcB;
        acc   <= '0;
        rem   <= '0;
        quo   <= SrcA;
        dz    <= op[1] && (SrcB == N'(0));
        RdOut <= RdIn;
      end else if (state == RUN) begin
        cnt  <= cnt + CW'(1);
        acc  <= acc_nx_c;
        mplr <= mplr >> 1;
        rem  <= rem_nx_c;
        quo  <= quo_nx_c;
        if (last_c) Result <= res_c;
      end
      busy <= (state_d == RUN);
      done <= (state_d == DONE);
      WE   <= (state_d == DONE) && (RdOut != M'(0));
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed vectors.
module tb_muldiv_unit;

  localparam int unsigned N = 32;
  localparam int unsigned M = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] SrcA, SrcB;
  logic [M-1:0] RdIn;
  logic         busy, done, WE;
  logic [N-1:0] Result;
  logic [M-1:0] RdOut;

  typedef struct {
    logic [N-1:0] res;
    logic [M-1:0] rd;
    logic         we;
    int unsigned  cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  muldiv_unit #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
    .RdIn(RdIn), .busy(busy), .done(done), .Result(Result), .RdOut(RdOut), .WE(WE)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Expected cycles from the start edge to the edge that raises done.
  function automatic int unsigned lat(input logic [1:0] o, input logic [N-1:0] b);
    int unsigned m;
    if (o[1]) return (b == '0) ? 1 : N;
`ifdef MULDIV_EARLY_OUT_EN
    m = 0;
    for (int i = 0; i < N; i++) if (b[i]) m = i;
    return m + 1;
`else
    m = N;
    return m;
`endif
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("result", Result, e.res);
        chk("rdout", 32'(RdOut), 32'(e.rd));
        chk("we", 32'(WE), 32'(e.we));
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [M-1:0] rd, input logic [N-1:0] res);
    exp_t e;
    start = 1'b1; op = o; SrcA = a; SrcB = b; RdIn = rd;
    @(posedge clk);
    #1;
    e.res = res; e.rd = rd; e.we = (rd != '0); e.cyc = cyc + lat(o, b);
    q.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; op = '0; SrcA = '0; SrcB = '0; RdIn = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(WE), 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_rdout", 32'(RdOut), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'd7, 32'd6, 5'd5, 32'd42);                    drain();
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE); drain();
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000001); drain();
    issue(2'b10, 32'd100, 32'd7, 5'd3, 32'd14);                   drain();
    issue(2'b11, 32'd100, 32'd7, 5'd4, 32'd2);                    drain();
    issue(2'b10, 32'd9, 32'd0, 5'd6, 32'hFFFFFFFF);               drain();
    issue(2'b11, 32'd9, 32'd0, 5'd7, 32'd9);                      drain();
    issue(2'b01, 32'h80000000, 32'd4, 5'd10, 32'd2);              drain();
    issue(2'b10, 32'hFFFFFFFF, 32'd1, 5'd9, 32'hFFFFFFFF);        drain();
    issue(2'b11, 32'd7, 32'd100, 5'd11, 32'd7);                   drain();
    repeat (3) @(negedge clk);
    chk("result_hold", Result, 32'd7);

    // start pulsed mid-RUN with new operands is ignored
    issue(2'b10, 32'd100, 32'd7, 5'd3, 32'd14);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b00; SrcA = 32'd50; SrcB = 32'd5; RdIn = 5'd12;
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // reset mid-RUN aborts the operation
    issue(2'b00, 32'd7, 32'd6, 5'd5, 32'd42);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_we", 32'(WE), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(2'b10, 32'd10, 32'd3, 5'd8, 32'd3);                     drain();

    // x0 destination: done pulses, no write enable
    issue(2'b00, 32'd2, 32'd3, 5'd0, 32'd6);                      drain();

    // back-to-back: start held while in DONE goes straight to RUN
    issue(2'b00, 32'd7, 32'd6, 5'd5, 32'd42);
    k = 0;
    while (k < 100 && done !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done_seen", 32'(done), 32'd1);
    issue(2'b10, 32'd100, 32'd7, 5'd3, 32'd14);
    chk("b2b_busy", 32'(busy), 32'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
